// File: rtl/mmm_pkg.sv
// mmm_pkg: shared state encoding and column-group helpers for the parallel matrix multiplier
package mmm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int groups(input int n, input int p);
    return (n + p - 1) / p;
  endfunction
  function automatic logic lane_on(input int g, input int p, input int pp, input int n);
    return g * pp + p < n;
  endfunction
endpackage

// File: rtl/mac_lane.sv
// mac_lane: registered signed product feeding an accumulator with optional saturation
module mac_lane #(
  parameter int INW  = 12,
  parameter int OUTW = 32,
  parameter int SAT  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_mul,
  input  logic                   en_acc,
  input  logic                   first,
  input  logic signed [INW-1:0]  a,
  input  logic signed [INW-1:0]  b,
  output logic signed [OUTW-1:0] acc
);
  logic signed [2*INW-1:0] prod;
  logic signed [OUTW:0]    sum;
  logic signed [OUTW-1:0]  nacc;
  logic                    ovf;
  // one guard bit exposes overflow; first beat of a dot product loads instead of adding
  assign sum  = (first ? '0 : $signed({acc[OUTW-1], acc})) + (OUTW+1)'(prod);
  assign ovf  = sum[OUTW] != sum[OUTW-1];
  assign nacc = (SAT != 0 && ovf) ? (sum[OUTW] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}})
                                  : sum[OUTW-1:0];
  always_ff @(posedge clk)
    if (!reset) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (en_mul) prod <= (2*INW)'(a) * (2*INW)'(b);
      if (en_acc) acc <= nacc;
    end
endmodule

// File: rtl/mmm_par.sv
// mmm_par: C = A*B computed P columns at a time, results streamed row-major on a valid/ready port
module mmm_par import mmm_pkg::*; #(
  parameter int INW    = 12,
  parameter int OUTW   = 32,
  parameter int M      = 7,
  parameter int N      = 9,
  parameter int MAXK   = 8,
  parameter int P      = 3,
  parameter int SAT    = 0,
  parameter int K_BITS = $clog2(MAXK + 1),
  parameter int AW     = $clog2(M * MAXK),
  parameter int BW     = $clog2(MAXK * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              matrices_loaded,
  output logic              compute_finished,
  input  logic [K_BITS-1:0] K,
  output logic [AW-1:0]     A_read_addr,
  input  logic [INW-1:0]    A_data,
  output logic [P*BW-1:0]   B_read_addr,
  input  logic [P*INW-1:0]  B_data,
  output logic [OUTW-1:0]   OUTPUT_TDATA,
  output logic              OUTPUT_TVALID,
  input  logic              OUTPUT_TREADY
);
  localparam int G  = groups(N, P);
  localparam int RW = M > 1 ? $clog2(M) : 1;
  localparam int GW = G > 1 ? $clog2(G) : 1;
  localparam int SW = P > 1 ? $clog2(P) : 1;
  state_t            state;
  logic [K_BITS-1:0] kreg, kk;
  logic [RW-1:0]     row, orow;
  logic [GW-1:0]     grp, ogrp;
  logic [SW-1:0]     sel;
  logic              issued, outst, final_k, iss, take, nxt, grp_done, last_word;
  logic              v1, v2, v3, f1, f2, l1, l2, l3;
  logic [OUTW-1:0]   acc [P];
  logic [OUTW-1:0]   bank [P];
  assign final_k          = K_BITS'(kk + 1'b1) == kreg;
  assign iss              = state == RUN && !issued && !(final_k && outst);
  assign take             = OUTPUT_TVALID && OUTPUT_TREADY;
  assign nxt              = (int'(sel) + 1 < P) && lane_on(int'(ogrp), int'(sel) + 1, P, N);
  assign grp_done         = take && !nxt;
  assign last_word        = grp_done && orow == RW'(M - 1) && ogrp == GW'(G - 1);
  assign compute_finished = state == DONE;
  assign A_read_addr      = AW'(int'(row) * int'(kreg) + int'(kk));
  assign OUTPUT_TDATA     = bank[sel];
  for (genvar p = 0; p < P; p++) begin : g_lane
    assign B_read_addr[p*BW +: BW] = (state == RUN && lane_on(int'(grp), p, P, N))
                                     ? BW'(int'(kk) * N + int'(grp) * P + p) : '0;
    mac_lane #(.INW(INW), .OUTW(OUTW), .SAT(SAT)) u_lane (
      .clk(clk), .reset(reset), .en_mul(v1), .en_acc(v2), .first(f2),
      .a(A_data), .b(B_data[p*INW +: INW]), .acc(acc[p])
    );
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state         <= IDLE;
      kreg          <= '0;
      kk            <= '0;
      row           <= '0;
      grp           <= '0;
      orow          <= '0;
      ogrp          <= '0;
      sel           <= '0;
      issued        <= 1'b0;
      outst         <= 1'b0;
      OUTPUT_TVALID <= 1'b0;
      {v1, v2, v3, f1, f2, l1, l2, l3} <= '0;
      for (int p = 0; p < P; p++) bank[p] <= '0;
    end else begin
      {v1, f1, l1} <= {iss, kk == '0, final_k};
      {v2, f2, l2} <= {v1, f1, l1};
      {v3, l3}     <= {v2, l2};
      if (state == IDLE && matrices_loaded) begin
        state  <= K == '0 ? DONE : RUN;
        kreg   <= K;
        issued <= 1'b0;
      end else if (state == DONE && !matrices_loaded) state <= IDLE;
      else if (last_word) state <= DONE;
      if (iss) begin
        kk <= final_k ? '0 : kk + 1'b1;
        if (final_k) begin
          grp <= grp == GW'(G - 1) ? '0 : grp + 1'b1;
          if (grp == GW'(G - 1)) begin
            row    <= row == RW'(M - 1) ? '0 : row + 1'b1;
            issued <= row == RW'(M - 1);
          end
        end
      end
      // at most one finished group waits in the bank; the next final-k issue holds until it drains
      outst <= (iss && final_k) || (outst && !grp_done);
      if (v3 && l3) begin
        for (int p = 0; p < P; p++) bank[p] <= acc[p];
        OUTPUT_TVALID <= 1'b1;
        sel           <= '0;
      end else if (take) begin
        OUTPUT_TVALID <= nxt;
        sel           <= nxt ? sel + 1'b1 : '0;
      end
      if (grp_done) begin
        ogrp <= ogrp == GW'(G - 1) ? '0 : ogrp + 1'b1;
        if (ogrp == GW'(G - 1)) orow <= orow == RW'(M - 1) ? '0 : orow + 1'b1;
      end
    end
endmodule

// File: tb/tb_mmm_par.sv
// tb_mmm_par: table-driven checks of mmm_par over three parameter sets plus a mid-run reset sequence
module tb_mmm_par;
  typedef struct {
    int     dsel;
    int     k;
    int     mode;
    int     av;
    int     bv;
    int     period;
    int     kind;
    longint exp;
    int     beats;
  } vec_t;
  logic clk = 0, reset = 0, ml = 0, tready = 0;
  logic [3:0] kin = '0;
  int dsel = 0, checks = 0, errors = 0;
  logic signed [11:0] amem [64];
  logic signed [11:0] bmem [128];
  logic ml0, ml1, ml2, cf0, cf1, cf2, tv0, tv1, tv2;
  logic [31:0] td0;
  logic [23:0] td1, td2;
  logic [5:0] aa0, aa1, aa2;
  logic [11:0] ad0, ad1, ad2;
  logic [20:0] ba0;
  logic [27:0] ba1, ba2;
  logic [35:0] bd0;
  logic [47:0] bd1, bd2;
  logic cf, tv;
  logic signed [31:0] td;
  always #5 clk = ~clk;
  assign ml0 = ml && dsel == 0;
  assign ml1 = ml && dsel == 1;
  assign ml2 = ml && dsel == 2;
  assign cf  = dsel == 0 ? cf0 : dsel == 1 ? cf1 : cf2;
  assign tv  = dsel == 0 ? tv0 : dsel == 1 ? tv1 : tv2;
  assign td  = dsel == 0 ? td0 : dsel == 1 ? {{8{td1[23]}}, td1} : {{8{td2[23]}}, td2};
  mmm_par u0 (.clk(clk), .reset(reset), .matrices_loaded(ml0), .compute_finished(cf0), .K(kin),
              .A_read_addr(aa0), .A_data(ad0), .B_read_addr(ba0), .B_data(bd0),
              .OUTPUT_TDATA(td0), .OUTPUT_TVALID(tv0), .OUTPUT_TREADY(tready));
  mmm_par #(.P(4), .OUTW(24), .SAT(1)) u1 (.clk(clk), .reset(reset), .matrices_loaded(ml1),
              .compute_finished(cf1), .K(kin), .A_read_addr(aa1), .A_data(ad1), .B_read_addr(ba1),
              .B_data(bd1), .OUTPUT_TDATA(td1), .OUTPUT_TVALID(tv1), .OUTPUT_TREADY(tready));
  mmm_par #(.P(4), .OUTW(24), .SAT(0)) u2 (.clk(clk), .reset(reset), .matrices_loaded(ml2),
              .compute_finished(cf2), .K(kin), .A_read_addr(aa2), .A_data(ad2), .B_read_addr(ba2),
              .B_data(bd2), .OUTPUT_TDATA(td2), .OUTPUT_TVALID(tv2), .OUTPUT_TREADY(tready));
  // synchronous-read memories, one read port per lane
  always_ff @(posedge clk) begin
    ad0 <= amem[aa0];
    ad1 <= amem[aa1];
    ad2 <= amem[aa2];
    for (int p = 0; p < 3; p++) bd0[p*12 +: 12] <= bmem[ba0[p*7 +: 7]];
    for (int p = 0; p < 4; p++) begin
      bd1[p*12 +: 12] <= bmem[ba1[p*7 +: 7]];
      bd2[p*12 +: 12] <= bmem[ba2[p*7 +: 7]];
    end
  end
  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic fill(input vec_t v);
    for (int i = 0; i < 64; i++)
      if (v.mode == 0) amem[i] = 12'(v.av);
      else if (v.mode == 1) amem[i] = i < 7 ? 12'(i + 1) : 12'(0);
      else amem[i] = 12'($urandom_range(0, 4095));
    for (int i = 0; i < 128; i++)
      if (v.mode == 0) bmem[i] = 12'(v.bv);
      else if (v.mode == 1) bmem[i] = i < 9 ? 12'(i) : 12'(0);
      else bmem[i] = 12'($urandom_range(0, 4095));
  endtask
  function automatic longint model(input int r, input int c, input int k, input int outw, input bit sat);
    longint acc = 0;
    longint hi = (longint'(1) <<< (outw - 1)) - 1;
    longint lo = -(longint'(1) <<< (outw - 1));
    for (int i = 0; i < k; i++) begin
      acc += longint'(amem[r*k+i]) * longint'(bmem[i*9+c]);
      if (sat) acc = acc > hi ? hi : (acc < lo ? lo : acc);
      else begin
        acc = acc & ((longint'(1) <<< outw) - 1);
        if (acc > hi) acc -= longint'(1) <<< outw;
      end
    end
    return acc;
  endfunction
  task automatic run_vec(input vec_t v, input int abort_at);
    int beats = 0, cyc = 0;
    bit stalled = 0, done = 0;
    logic signed [31:0] held = 0;
    longint exp;
    dsel = v.dsel;
    fill(v);
    kin = 4'(v.k);
    ml = 1;
    while (!done && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (stalled) begin
        check("hold_valid", tv, 1);
        check("hold_data", td, held);
      end
      if (cf) done = 1;
      else begin
        tready  = (cyc % v.period) == 0;
        stalled = tv && !tready;
        held    = td;
        if (tv && tready) begin
          if (beats >= v.beats) check("extra_beat", beats + 1, v.beats);
          else begin
            exp = v.kind == 0 ? v.exp
                : v.kind == 1 ? longint'((beats / 9 + 1) * (beats % 9))
                : model(beats / 9, beats % 9, v.k, dsel == 0 ? 32 : 24, dsel == 1);
            check($sformatf("beat%0d_d%0d_k%0d", beats, v.dsel, v.k), td, exp);
          end
          beats++;
          if (beats == abort_at) begin
            @(posedge clk);
            #1;
            reset  = 0;
            tready = 0;
            @(posedge clk);
            #1;
            reset = 1;
            check("abort_tvalid", tv0, 0);
            check("abort_finished", cf0, 0);
            check("abort_a_addr", aa0, 0);
            check("abort_b_addr", ba0, 0);
            return;
          end
        end
      end
    end
    check("finish_seen", done, 1);
    check("beat_count", beats, v.beats);
    tready = 1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("finished_held", cf, 1);
      check("no_beat_in_done", tv, 0);
    end
    ml = 0;
    @(posedge clk);
    #1;
    check("finished_drop", cf, 0);
  endtask
  vec_t vecs [11];
  initial begin
    vecs[0]  = '{0, 8, 0, 1, 2, 1, 0, 16, 63};
    vecs[1]  = '{1, 1, 1, 0, 0, 1, 1, 0, 63};
    vecs[2]  = '{0, 8, 0, 1, 2, 3, 0, 16, 63};
    vecs[3]  = '{1, 8, 0, -2048, -2048, 1, 0, 8388607, 63};
    vecs[4]  = '{2, 8, 0, -2048, -2048, 1, 0, 0, 63};
    vecs[5]  = '{2, 1, 1, 0, 0, 2, 1, 0, 63};
    vecs[6]  = '{0, 0, 0, 1, 2, 1, 0, 0, 0};
    vecs[7]  = '{0, 5, 2, 0, 0, 2, 2, 0, 63};
    vecs[8]  = '{1, 8, 2, 0, 0, 1, 2, 0, 63};
    vecs[9]  = '{2, 3, 2, 0, 0, 3, 2, 0, 63};
    vecs[10] = '{0, 1, 2, 0, 0, 1, 2, 0, 63};
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid0", tv0, 0);
    check("rst_tvalid1", tv1, 0);
    check("rst_tvalid2", tv2, 0);
    check("rst_finished0", cf0, 0);
    check("rst_a_addr0", aa0, 0);
    check("rst_b_addr0", ba0, 0);
    check("rst_b_addr1", ba1, 0);
    reset = 1;
    for (int i = 0; i < 11; i++) run_vec(vecs[i], 0);
    run_vec(vecs[7], 10);
    run_vec(vecs[0], 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mmm_par.md
MMM_PAR -- requirements
Module: mmm_par

Interface
REQ-001 INW, 12, signed operand width.
REQ-002 OUTW, 32, signed result width.
REQ-003 M, 7, rows of A and C.
REQ-004 N, 9, columns of B and C.
REQ-005 MAXK, 8, max inner dimension; K_BITS = $clog2(MAXK+1).
REQ-006 P, 3, parallel MAC lanes; 1 <= P <= N.
REQ-007 SAT, 0, 1 = accumulator saturates at OUTW signed limits; 0 = two's-complement wrap.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-010 matrices_loaded  in  1  A and B memories hold valid data.
REQ-011 compute_finished  out  1  matrix done; held until matrices_loaded falls.
REQ-012 K  in  K_BITS  inner dimension; valid while matrices_loaded=1.
REQ-013 A_read_addr  out  $clog2(M*MAXK)  A address, row-major, = row*K + k.
REQ-014 A_data  in  INW  A word; synchronous read, valid one cycle after its address.
REQ-015 B_read_addr  out  P*$clog2(MAXK*N)  lane p slice = k*N + col_p.
REQ-016 B_data  in  P*INW  lane p slice; one-cycle read latency.
REQ-017 OUTPUT_TDATA  out  OUTW  result word.
REQ-018 OUTPUT_TVALID  out  1  result valid.
REQ-019 OUTPUT_TREADY  in  1  downstream accepts.

Function
REQ-020 Columns SHALL be split into G = ceil(N/P) groups; lane p of group g computes col_p = g*P+p; lanes with col_p >= N are masked: B address 0, result never emitted.
REQ-021 States SHALL be IDLE, RUN, DONE; reset enters IDLE.
REQ-022 IDLE -> RUN when matrices_loaded=1 and K>=1, latching K into kreg; IDLE -> DONE when matrices_loaded=1 and K=0, with no output.
REQ-023 RUN: each non-stalled cycle issues one (row, group, k) address set; order: k fastest, then group, then row.
REQ-024 A group's final-k issue (k=kreg-1) SHALL stall, holding addresses, while a previous group is outstanding (final k issued, results not all emitted); non-final issues never stall.
REQ-025 Pipeline: issue cycle t; data t+1; registered product t+2; accumulator t+3, loaded (not added) on k=0; result bank captures all lanes at t+4; OUTPUT_TVALID may first rise at t+4.
REQ-026 Products SHALL be full 2*INW signed, sign-extended to OUTW; when SAT=1, a sum exceeding the OUTW signed range clamps to the nearer limit, and later sums use the clamped value.
REQ-027 The serializer SHALL emit the unmasked lanes in lane order, one per OUTPUT_TVALID&&OUTPUT_TREADY cycle; overall output order is C row-major.
REQ-028 While OUTPUT_TVALID=1 and OUTPUT_TREADY=0, OUTPUT_TDATA SHALL hold stable; OUTPUT_TVALID SHALL not drop before the beat is accepted.
REQ-029 RUN -> DONE after the last word of C is accepted; compute_finished=1 throughout DONE.
REQ-030 DONE -> IDLE when matrices_loaded=0; compute_finished falls in the same transition.
REQ-031 matrices_loaded falling during RUN SHALL be ignored; exactly M*N words are still emitted.

Reset
REQ-032 Reset SHALL set state IDLE, OUTPUT_TVALID=0, compute_finished=0, all addresses 0, accumulators, bank and counters 0, outstanding flag 0.
REQ-033 Reset mid-RUN SHALL discard all in-flight and banked results; no stale beat follows.

Structure
REQ-034 Package mmm_pkg SHALL hold the state enum, a group-count function ceil(N/P), and a lane-mask function.
REQ-035 Sub-module mac_lane (product register, accumulator, SAT clamp) SHALL be instantiated P times by generate.

Verification
REQ-036 P=3, N=9, M=7, K=8, A all 1, B all 2, TREADY=1 -> 63 beats, each 16; compute_finished rises after beat 63.
REQ-037 P=4, N=9, K=1, A[r][0]=r+1, B[0][c]=c -> 63 beats, C[r][c]=(r+1)*c, row-major; no beats for masked lanes.
REQ-038 Case of REQ-036 with TREADY high 1 cycle in 3 -> identical 63 values; TDATA stable across every stalled cycle.
REQ-039 INW=12, OUTW=24, K=8, all A and B = -2048 -> SAT=1 gives 8388607 per word; SAT=0 gives 0.
REQ-040 reset=0 for one cycle after beat 10 -> TVALID=0 next cycle, state IDLE; the rerun emits all 63 correct words.
REQ-041 K=0 with matrices_loaded=1 -> no beats, compute_finished=1 until matrices_loaded=0, then 0.
